mcu_mem_arbiter: RTL and testbench

//  Shares one synchronous single-port register RAM between three users: the MCU

---
 rtl/mcu_mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mcu_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_mem_arbiter.sv
// mcu_mem_arbiter: shares one synchronous single-port RAM between a posted
// MCU write stream, an MCU read mirror and one req/ack internal requester.
// One slot per cycle, all RAM port signals registered, with starvation
// limits on the requester (burst limit) and on the mirror (refresh limit).
module mcu_mem_arbiter #(
    parameter int AW            = 16,
    parameter int DW            = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int MCU_BURST_MAX = 4,
    parameter int REF_MAX       = 16
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              mcu_write,
    input  logic [AW-1:0]     mcu_wraddr,
    input  logic [DW-1:0]     mcu_wrdata,
    input  logic [DW/8-1:0]   mcu_be,
    input  logic [AW-1:0]     mcu_rdaddr,
    output logic [DW-1:0]     mcu_rddata,
    output logic              wr_ovf,
    input  logic              ovf_clr,
    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [AW-1:0]     usr_addr,
    input  logic [DW-1:0]     usr_wdata,
    input  logic [DW/8-1:0]   usr_be,
    output logic              usr_ack,
    output logic              usr_rvalid,
    output logic [DW-1:0]     usr_rdata,
    output logic [AW-2:0]     mem_addr,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int BW  = DW / 8;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int BCW = $clog2(MCU_BURST_MAX + 1);
    localparam int RCW = $clog2(REF_MAX + 1);

    localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [BCW-1:0] BURST_LIM = BCW'(MCU_BURST_MAX);
    localparam logic [RCW-1:0] REF_LIM   = RCW'(REF_MAX - 1);

    typedef struct packed {
        logic [AW-2:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } wr_entry_t;

    typedef enum logic [1:0] {
        SL_REF = 2'd0,
        SL_MCU = 2'd1,
        SL_USR = 2'd2
    } slot_t;

    // posting FIFO
    wr_entry_t      r_fifo [FIFO_DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    // scheduler state
    logic [BCW-1:0] r_burst;
    logic [RCW-1:0] r_ref_cnt;
    logic           r_ack;
    logic           r_rvalid;
    logic           r_ref_p1;
    logic           r_ref_p2;
    logic           r_ovf;
    logic [AW-2:0]  r_mem_addr;
    logic           r_mem_we;
    logic [BW-1:0]  r_mem_be;
    logic [DW-1:0]  r_mem_wdata;
    logic [DW-1:0]  r_rddata;

    wr_entry_t      w_head;
    wr_entry_t      w_new;
    logic           w_empty;
    logic           w_full;
    logic           w_elig;
    slot_t          w_slot;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic           w_unused;

    // Byte-lane bit 0 of every address is meaningless on a word RAM.
    assign w_unused = ^{mcu_wraddr[0], usr_addr[0], mcu_rdaddr[0]};

    assign w_head  = r_fifo[r_rptr];
    assign w_new   = '{addr: mcu_wraddr[AW-1:1], data: mcu_wrdata, be: mcu_be};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FIFO_FULL);
    // usr_req is still high during its own ack cycle; it must not re-grant.
    assign w_elig  = usr_req & ~r_ack;
    assign w_pop   = (w_slot == SL_MCU);
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign w_push  = mcu_write & (~w_full | w_pop);
    assign w_drop  = mcu_write & w_full & ~w_pop;

    // Slot choice: forced refresh, forced user, MCU write, user, idle refresh.
    always_comb begin
        w_slot = SL_REF;
        if (r_ref_cnt >= REF_LIM) begin
            w_slot = SL_REF;
        end else if ((r_burst == BURST_LIM) && w_elig) begin
            w_slot = SL_USR;
        end else if (!w_empty) begin
            w_slot = SL_MCU;
        end else if (w_elig) begin
            w_slot = SL_USR;
        end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_new;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (aclr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered RAM port, handshakes, read returns and starvation counters.
    always_ff @(posedge clk) begin
        if (aclr) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_ack       <= 1'b0;
            r_rvalid    <= 1'b0;
            r_ref_p1    <= 1'b0;
            r_ref_p2    <= 1'b0;
            r_rddata    <= '0;
            r_ovf       <= 1'b0;
            r_burst     <= '0;
            r_ref_cnt   <= '0;
        end else begin
            case (w_slot)
                SL_MCU: begin
                    r_mem_addr  <= w_head.addr;
                    r_mem_we    <= 1'b1;
                    r_mem_be    <= w_head.be;
                    r_mem_wdata <= w_head.data;
                end
                SL_USR: begin
                    r_mem_addr  <= usr_addr[AW-1:1];
                    r_mem_we    <= usr_we;
                    r_mem_be    <= usr_be;
                    r_mem_wdata <= usr_wdata;
                end
                default: begin
                    r_mem_addr  <= mcu_rdaddr[AW-1:1];
                    r_mem_we    <= 1'b0;
                    r_mem_be    <= '0;
                    r_mem_wdata <= '0;
                end
            endcase

            r_ack    <= (w_slot == SL_USR);
            // the RAM answers the cycle after the address, so the read
            // return lines up with the cycle following the ack
            r_rvalid <= r_ack & ~r_mem_we;
            r_ref_p1 <= (w_slot == SL_REF);
            r_ref_p2 <= r_ref_p1;
            if (r_ref_p2) begin
                r_rddata <= mem_rdata;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if ((w_slot == SL_USR) || !usr_req) begin
                r_burst <= '0;
            end else if ((w_slot == SL_MCU) && (r_burst != BURST_LIM)) begin
                r_burst <= r_burst + 1'b1;
            end

            if (w_slot == SL_REF) begin
                r_ref_cnt <= '0;
            end else if (r_ref_cnt < REF_LIM) begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign usr_ack    = r_ack;
    assign usr_rvalid = r_rvalid;
    assign usr_rdata  = r_rvalid ? mem_rdata : '0;
    assign mcu_rddata = r_rddata;
    assign wr_ovf     = r_ovf;

endmodule

// File: tb/tb_mcu_mem_arbiter.sv
// Bench for mcu_mem_arbiter: directed scenarios plus a randomized phase, all
// compared every cycle against a queue-based reference model with its own
// shadow copy of the RAM.
module tb_mcu_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int FD = 2;
    localparam int BM = 1;
    localparam int RM = 8;

    logic          clk;
    logic          aclr;
    logic          mcu_write;
    logic [15:0]   mcu_wraddr;
    logic [15:0]   mcu_wrdata;
    logic [1:0]    mcu_be;
    logic [15:0]   mcu_rdaddr;
    logic [15:0]   mcu_rddata;
    logic          wr_ovf;
    logic          ovf_clr;
    logic          usr_req;
    logic          usr_we;
    logic [15:0]   usr_addr;
    logic [15:0]   usr_wdata;
    logic [1:0]    usr_be;
    logic          usr_ack;
    logic          usr_rvalid;
    logic [15:0]   usr_rdata;
    logic [14:0]   mem_addr;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    mcu_mem_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(FD), .MCU_BURST_MAX(BM), .REF_MAX(RM)
    ) dut (
        .clk(clk), .aclr(aclr),
        .mcu_write(mcu_write), .mcu_wraddr(mcu_wraddr), .mcu_wrdata(mcu_wrdata),
        .mcu_be(mcu_be), .mcu_rdaddr(mcu_rdaddr), .mcu_rddata(mcu_rddata),
        .wr_ovf(wr_ovf), .ovf_clr(ovf_clr),
        .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr),
        .usr_wdata(usr_wdata), .usr_be(usr_be), .usr_ack(usr_ack),
        .usr_rvalid(usr_rvalid), .usr_rdata(usr_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical synchronous RAM (64 words used), with a preload port.
    logic [15:0] ram [0:63];
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [15:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_we) begin
            for (int b = 0; b < 2; b++) begin
                if (mem_be[b]) ram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        mem_rdata <= ram[mem_addr[5:0]];
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [14:0] a;
        logic [15:0] d;
        logic [1:0]  b;
    } went_t;

    went_t       fq[$];
    logic [15:0] ref_mem [0:63];
    int          m_burst, m_ref, m_drops;
    logic [14:0] e_addr;
    logic        e_we;
    logic [1:0]  e_be;
    logic [15:0] e_wdata;
    logic        e_ack, e_rvalid, e_ovf;
    logic [15:0] e_rdata, e_rddata;
    logic        p1_v, p2_v;
    logic [15:0] p1_d, p2_d, ur_data;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic void mem_wr(input logic [14:0] a, input logic [15:0] d, input logic [1:0] b);
        for (int i = 0; i < 2; i++) begin
            if (b[i]) ref_mem[a[5:0]][i*8 +: 8] = d[i*8 +: 8];
        end
    endfunction

    // What the arbiter must do at the coming clock edge, from current inputs.
    task automatic model_edge();
        int    slot;
        bit    elig;
        bit    drop;
        went_t ent;
        if (aclr) begin
            fq.delete();
            m_burst = 0; m_ref = 0;
            e_addr = '0; e_we = 0; e_be = '0; e_wdata = '0;
            e_ack = 0; e_rvalid = 0; e_rdata = '0; e_rddata = '0; e_ovf = 0;
            p1_v = 0; p2_v = 0; p1_d = '0; p2_d = '0; ur_data = '0;
            return;
        end
        elig = usr_req && !e_ack;
        if (m_ref >= RM - 1)                slot = 0;
        else if (m_burst == BM && elig)     slot = 2;
        else if (fq.size() != 0)            slot = 1;
        else if (elig)                      slot = 2;
        else                                slot = 0;

        e_rvalid = e_ack && !e_we;
        e_rdata  = e_rvalid ? ur_data : 16'h0;
        if (p2_v) e_rddata = p2_d;
        p2_v = p1_v;
        p2_d = p1_d;
        p1_v = 0;

        case (slot)
            0: begin
                e_addr = mcu_rdaddr[15:1]; e_we = 0; e_be = '0; e_wdata = '0;
                p1_v = 1;
                p1_d = ref_mem[mcu_rdaddr[6:1]];
            end
            1: begin
                ent = fq.pop_front();
                e_addr = ent.a; e_we = 1; e_be = ent.b; e_wdata = ent.d;
                mem_wr(ent.a, ent.d, ent.b);
            end
            default: begin
                e_addr = usr_addr[15:1]; e_we = usr_we; e_be = usr_be; e_wdata = usr_wdata;
                if (usr_we) mem_wr(usr_addr[15:1], usr_wdata, usr_be);
                else        ur_data = ref_mem[usr_addr[6:1]];
            end
        endcase
        e_ack = (slot == 2);

        drop = 0;
        if (mcu_write) begin
            if (fq.size() < FD) begin
                ent.a = mcu_wraddr[15:1]; ent.d = mcu_wrdata; ent.b = mcu_be;
                fq.push_back(ent);
            end else begin
                drop = 1;
                m_drops++;
            end
        end
        if (drop)         e_ovf = 1;
        else if (ovf_clr) e_ovf = 0;

        if (slot == 2 || !usr_req)        m_burst = 0;
        else if (slot == 1 && m_burst < BM) m_burst++;
        if (slot == 0)        m_ref = 0;
        else if (m_ref < RM - 1) m_ref++;
    endtask

    task automatic compare_all();
        chk("mem_addr",   32'(mem_addr),   32'(e_addr));
        chk("mem_we",     32'(mem_we),     32'(e_we));
        chk("mem_be",     32'(mem_be),     32'(e_be));
        chk("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
        chk("usr_ack",    32'(usr_ack),    32'(e_ack));
        chk("usr_rvalid", 32'(usr_rvalid), 32'(e_rvalid));
        chk("usr_rdata",  32'(usr_rdata),  32'(e_rdata));
        chk("mcu_rddata", 32'(mcu_rddata), 32'(e_rddata));
        chk("wr_ovf",     32'(wr_ovf),     32'(e_ovf));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic new_req();
        usr_req   = 1'b1;
        usr_we    = 1'($urandom_range(0, 1));
        usr_addr  = 16'($urandom_range(0, 127));
        usr_wdata = 16'($urandom);
        usr_be    = 2'($urandom_range(0, 3));
    endtask

    // Requester: fields stay fixed until the ack, then a new request or idle.
    task automatic usr_drive();
        if (usr_req) begin
            if (e_ack) begin
                if ($urandom_range(0, 2) == 0) usr_req = 1'b0;
                else new_req();
            end
        end else if ($urandom_range(0, 3) == 0) begin
            new_req();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_we, n_rv, n_ack, last_ack, max_gap, gap, drops0;
        bit got;

        aclr = 1'b1; mcu_write = 0; mcu_wraddr = '0; mcu_wrdata = '0; mcu_be = '0;
        mcu_rdaddr = '0; ovf_clr = 0; usr_req = 0; usr_we = 0; usr_addr = '0;
        usr_wdata = '0; usr_be = '0; ld_en = 0; ld_addr = '0; ld_data = '0;
        m_drops = 0;

        // reset while preloading RAM and its shadow
        for (int i = 0; i < 64; i++) begin
            ld_en   = 1'b1;
            ld_addr = 6'(i);
            ld_data = (i == 8) ? 16'hBEEF : 16'($urandom);
            ref_mem[i] = ld_data;
            tick();
        end
        ld_en = 1'b0;
        chk("rst_mem_we",   32'(mem_we),     32'd0);
        chk("rst_usr_ack",  32'(usr_ack),    32'd0);
        chk("rst_rddata",   32'(mcu_rddata), 32'd0);
        chk("rst_wr_ovf",   32'(wr_ovf),     32'd0);

        // idle read mirror
        aclr = 1'b0;
        mcu_rdaddr = 16'h0010;
        tick();
        chk("mirror_addr", 32'(mem_addr), 32'h0008);
        tick();
        tick();
        chk("mirror_data", 32'(mcu_rddata), 32'hBEEF);

        // posted write
        mcu_write = 1; mcu_wraddr = 16'h0004; mcu_wrdata = 16'h1234; mcu_be = 2'b11;
        tick();
        mcu_write = 0;
        chk("pw_early_we", 32'(mem_we), 32'd0);
        tick();
        chk("pw_we",    32'(mem_we),    32'd1);
        chk("pw_addr",  32'(mem_addr),  32'h0002);
        chk("pw_wdata", 32'(mem_wdata), 32'h1234);
        tick();
        chk("pw_one_cycle", 32'(mem_we), 32'd0);

        // user read while idle
        usr_req = 1; usr_we = 0; usr_addr = 16'h0020; usr_be = 2'b11; usr_wdata = '0;
        tick();
        chk("ur_ack",  32'(usr_ack),  32'd1);
        chk("ur_addr", 32'(mem_addr), 32'h0010);
        usr_req = 0;
        tick();
        chk("ur_rvalid", 32'(usr_rvalid), 32'd1);
        chk("ur_rdata",  32'(usr_rdata),  32'(ref_mem[16]));
        repeat (3) tick();

        // fairness and overflow: user held, 6 back-to-back MCU writes
        drops0 = m_drops; n_we = 0; n_ack = 0; last_ack = -1; max_gap = 0;
        usr_req = 1; usr_we = 0; usr_addr = 16'h0030;
        for (int c = 0; c < 16; c++) begin
            mcu_write  = (c < 6);
            mcu_wraddr = 16'(2 * c);
            mcu_wrdata = 16'(16'hA000 + c);
            mcu_be     = 2'b11;
            tick();
            if (mem_we) n_we++;
            if (usr_ack) begin
                if (last_ack >= 0 && (c - last_ack) > max_gap) max_gap = c - last_ack;
                last_ack = c;
                n_ack++;
            end
        end
        mcu_write = 0; usr_req = 0;
        chk("fair_ovf",       32'(wr_ovf), 32'd1);
        chk("fair_drops_seen", 32'(m_drops - drops0 > 0), 32'd1);
        chk("fair_wr_count",  32'(n_we), 32'(6 - (m_drops - drops0)));
        chk("fair_acks",      32'(n_ack >= 5), 32'd1);
        chk("fair_gap",       32'(max_gap <= 3), 32'd1);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("ovf_clr", 32'(wr_ovf), 32'd0);
        repeat (6) tick();

        // forced refresh under saturation
        gap = 0; max_gap = 0;
        usr_req = 1; usr_we = 0; usr_addr = 16'h0012;
        for (int c = 0; c < 40; c++) begin
            mcu_write  = 1;
            mcu_wraddr = 16'($urandom_range(0, 127));
            mcu_wrdata = 16'($urandom);
            mcu_be     = 2'($urandom_range(1, 3));
            tick();
            if (!mem_we && !usr_ack) gap = 0;
            else gap++;
            if (gap > max_gap) max_gap = gap;
        end
        mcu_write = 0; usr_req = 0;
        chk("ref_gap", 32'(max_gap <= RM - 1), 32'd1);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        repeat (8) tick();

        // reset in the ack cycle of a read, with a posted write pending
        usr_req = 1; usr_we = 0; usr_addr = 16'h0030;
        mcu_write = 1; mcu_wraddr = 16'h0040; mcu_wrdata = 16'h5A5A; mcu_be = 2'b11;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            mcu_write = 0;
            if (usr_ack) got = 1;
        end
        chk("mid_ack_seen", 32'(got), 32'd1);
        if (got) begin
            aclr = 1; usr_req = 0;
            tick();
            aclr = 0;
            chk("mid_mem_addr",  32'(mem_addr),   32'd0);
            chk("mid_mem_we",    32'(mem_we),     32'd0);
            chk("mid_mem_be",    32'(mem_be),     32'd0);
            chk("mid_mem_wdata", 32'(mem_wdata),  32'd0);
            chk("mid_usr_ack",   32'(usr_ack),    32'd0);
            chk("mid_rvalid",    32'(usr_rvalid), 32'd0);
            chk("mid_rdata",     32'(usr_rdata),  32'd0);
            chk("mid_rddata",    32'(mcu_rddata), 32'd0);
            chk("mid_ovf",       32'(wr_ovf),     32'd0);
            n_we = 0; n_rv = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (mem_we) n_we++;
                if (usr_rvalid) n_rv++;
            end
            chk("mid_fifo_empty", 32'(n_we), 32'd0);
            chk("mid_no_rvalid",  32'(n_rv), 32'd0);
        end

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            mcu_write  = ($urandom_range(0, 99) < 45);
            mcu_wraddr = 16'($urandom_range(0, 127));
            mcu_wrdata = 16'($urandom);
            mcu_be     = 2'($urandom_range(0, 3));
            ovf_clr    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) mcu_rdaddr = 16'($urandom_range(0, 127));
            tick();
            usr_drive();
        end
        mcu_write = 0; ovf_clr = 0; usr_req = 0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
